// File: rtl/slice_adder_sequencer_if.sv
// Request, result and slice-side signals of the slice adder sequencer.
// master: requester/slice owner side; slave: sequencer side.
interface slice_adder_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] operand1_i;
  logic [WIDTH-1:0] operand2_i;
  logic             carry_i;
  logic             sub_i;
  logic [3:0]       slice_op1_o;
  logic [3:0]       slice_op2_o;
  logic             slice_carry_o;
  logic             slice_en_o;
  logic [3:0]       slice_sum_i;
  logic             slice_carry_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] sum_o;
  logic             carry_o;
  logic             overflow_o;
  logic             busy_o;

  modport master (
    output valid_i, operand1_i, operand2_i, carry_i, sub_i, ready_i,
           slice_sum_i, slice_carry_i,
    input  ready_o, slice_op1_o, slice_op2_o, slice_carry_o, slice_en_o,
           valid_o, sum_o, carry_o, overflow_o, busy_o
  );

  modport slave (
    input  valid_i, operand1_i, operand2_i, carry_i, sub_i, ready_i,
           slice_sum_i, slice_carry_i,
    output ready_o, slice_op1_o, slice_op2_o, slice_carry_o, slice_en_o,
           valid_o, sum_o, carry_o, overflow_o, busy_o
  );
endinterface

// File: rtl/slice_adder_sequencer.sv
// Wide add/subtract sequenced through one external 4-bit adder slice,
// one nibble per cycle LSB first, carry chained through a register.
module slice_adder_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input logic                   clk_i,
  input logic                   rst_i,
  slice_adder_sequencer_if.slave bus
);
  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e state, state_nxt;

  logic [WIDTH-1:0] a_q, b_q, acc_q, sum_q;
  logic [IDX_W-1:0] idx_q;
  logic             c_q, a_msb_q, b_msb_q;
  logic             carry_q, ovf_q;
  logic             ready_q, valid_q, en_q, busy_q;

  logic             accept_c, last_c;
  logic [WIDTH+3:0] acc_ext_c;
  logic [WIDTH-1:0] acc_nxt_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state; the result accumulator fills from the top so the last
  // pass leaves every nibble in place.
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    acc_ext_c = {bus.slice_sum_i, acc_q};
    acc_nxt_c = acc_ext_c[WIDTH+3:4];
    case (state)
      IDLE: begin
        if (bus.valid_i && ready_q) begin
          accept_c  = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (idx_q == IDX_W'(NIBBLES - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands shift right each pass, so the slice always sees bits [3:0]
  // and they drain to zero by the time RUN ends.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      valid_q <= (state_nxt == DONE);
      en_q    <= (state_nxt == RUN);
      busy_q  <= (state_nxt != IDLE);
      if (accept_c) begin
        a_q     <= bus.operand1_i;
        b_q     <= bus.sub_i ? ~bus.operand2_i : bus.operand2_i;
        c_q     <= bus.sub_i ? 1'b1 : bus.carry_i;
        a_msb_q <= bus.operand1_i[WIDTH-1];
        b_msb_q <= bus.sub_i ? ~bus.operand2_i[WIDTH-1] : bus.operand2_i[WIDTH-1];
        acc_q   <= '0;
        idx_q   <= '0;
      end else if (state == RUN) begin
        a_q   <= a_q >> 4;
        b_q   <= b_q >> 4;
        acc_q <= acc_nxt_c;
        if (last_c) begin
          idx_q   <= '0;
          c_q     <= 1'b0;
          sum_q   <= acc_nxt_c;
          carry_q <= bus.slice_carry_i;
          ovf_q   <= (a_msb_q == b_msb_q) && (acc_nxt_c[WIDTH-1] != a_msb_q);
        end else begin
          idx_q <= idx_q + IDX_W'(1);
          c_q   <= bus.slice_carry_i;
        end
      end
    end
  end

  assign bus.ready_o       = ready_q;
  assign bus.valid_o       = valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.slice_en_o    = en_q;
  assign bus.slice_op1_o   = a_q[3:0];
  assign bus.slice_op2_o   = b_q[3:0];
  assign bus.slice_carry_o = c_q;
  assign bus.sum_o         = sum_q;
  assign bus.carry_o       = carry_q;
  assign bus.overflow_o    = ovf_q;
endmodule

// File: tb/tb_slice_adder_sequencer.sv
// Bench for slice_adder_sequencer at WIDTH=16 and WIDTH=4, each with a
// behavioural 4-bit slice and a whole-word arithmetic reference model.
module tb_slice_adder_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  slice_adder_sequencer_if #(.WIDTH(16)) b16 ();
  slice_adder_sequencer_if #(.WIDTH(4))  b4 ();

  slice_adder_sequencer #(.WIDTH(16)) dut16 (.clk_i(clk), .rst_i(rst), .bus(b16));
  slice_adder_sequencer #(.WIDTH(4))  dut4  (.clk_i(clk), .rst_i(rst), .bus(b4));

  // The external slice: plain 4-bit add with carry.
  always_comb {b16.slice_carry_i, b16.slice_sum_i} =
    5'(b16.slice_op1_o) + 5'(b16.slice_op2_o) + 5'(b16.slice_carry_o);
  always_comb {b4.slice_carry_i, b4.slice_sum_i} =
    5'(b4.slice_op1_o) + 5'(b4.slice_op2_o) + 5'(b4.slice_carry_o);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Whole-word reference: subtract is a - b with carry meaning "no borrow".
  function automatic void model(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                                input logic cin, input logic sub,
                                output logic [31:0] s, output logic co, output logic ov);
    longint unsigned la, lb, full, mask;
    logic sa, sb, ss;
    la   = 64'(a);
    lb   = 64'(b);
    mask = (64'd1 << w) - 64'd1;
    if (sub) begin
      full = (la + (64'd1 << w) - lb) & mask;
      co   = (la >= lb);
    end else begin
      full = la + lb + 64'(cin);
      co   = full[w];
      full = full & mask;
    end
    s  = 32'(full);
    sa = a[w-1];
    sb = b[w-1];
    ss = s[w-1];
    ov = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
  endfunction

  task automatic txn16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub, input int hold, input bit keep_valid);
    logic [31:0] es;
    logic eco, eov;
    int t, lat, en_cnt, bad_run;
    model(16, 32'(a), 32'(b), cin, sub, es, eco, eov);
    @(negedge clk);
    t = 0;
    while (!b16.ready_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tag, ":ready"}, 32'(b16.ready_o), 32'd1);
    b16.operand1_i = a;
    b16.operand2_i = b;
    b16.carry_i    = cin;
    b16.sub_i      = sub;
    b16.valid_i    = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_valid) b16.valid_i = 1'b0;
    lat = 0; en_cnt = 0; bad_run = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (b16.valid_o) break;
      if (b16.slice_en_o) en_cnt++;
      if (b16.ready_o || !b16.busy_o) bad_run++;
      @(posedge clk);
      lat++;
    end
    b16.valid_i = 1'b0;
    check({tag, ":latency"}, 32'(lat), 32'd4);
    check({tag, ":en_cycles"}, 32'(en_cnt), 32'd4);
    check({tag, ":run_ready"}, 32'(bad_run), 32'd0);
    check({tag, ":sum"}, 32'(b16.sum_o), es);
    check({tag, ":carry"}, 32'(b16.carry_o), 32'(eco));
    check({tag, ":ovf"}, 32'(b16.overflow_o), 32'(eov));
    check({tag, ":done_en"}, 32'(b16.slice_en_o), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ":hold_valid"}, 32'(b16.valid_o), 32'd1);
      check({tag, ":hold_sum"}, {15'd0, b16.carry_o, b16.sum_o}, {15'd0, eco, es[15:0]});
    end
    b16.ready_i = 1'b1;
    @(posedge clk);
    #1;
    b16.ready_i = 1'b0;
    @(negedge clk);
    check({tag, ":post_ready"}, {30'd0, b16.ready_o, b16.valid_o}, 32'd2);
  endtask

  task automatic b2b16();
    logic [15:0] oa[3], ob[3];
    logic oc[3], os[3];
    logic [31:0] es[3];
    logic eco[3], eov[3];
    int acc_cyc[3];
    int cyc, na, nr;
    for (int k = 0; k < 3; k++) begin
      oa[k] = 16'($urandom); ob[k] = 16'($urandom);
      oc[k] = 1'($urandom);  os[k] = 1'($urandom);
      model(16, 32'(oa[k]), 32'(ob[k]), oc[k], os[k], es[k], eco[k], eov[k]);
    end
    @(negedge clk);
    b16.ready_i = 1'b1;
    b16.operand1_i = oa[0]; b16.operand2_i = ob[0]; b16.carry_i = oc[0]; b16.sub_i = os[0];
    b16.valid_i = 1'b1;
    cyc = 0; na = 0; nr = 0;
    while (nr < 3 && cyc < 200) begin
      if (b16.valid_o) begin
        check("b2b16:sum", {14'd0, b16.overflow_o, b16.carry_o, b16.sum_o},
              {14'd0, eov[nr], eco[nr], es[nr][15:0]});
        nr++;
      end
      if (b16.valid_i && b16.ready_o && na < 3) begin
        acc_cyc[na] = cyc;
        na++;
        @(posedge clk);
        #1;
        if (na < 3) begin
          b16.operand1_i = oa[na]; b16.operand2_i = ob[na];
          b16.carry_i = oc[na]; b16.sub_i = os[na];
        end else b16.valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    b16.valid_i = 1'b0;
    b16.ready_i = 1'b0;
    check("b2b16:results", 32'(nr), 32'd3);
    check("b2b16:gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);
    check("b2b16:gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd6);
  endtask

  task automatic b2b4();
    logic [3:0] oa[3], ob[3];
    logic oc[3], os[3];
    logic [31:0] es[3];
    logic eco[3], eov[3];
    int acc_cyc[3];
    int cyc, na, nr;
    for (int k = 0; k < 3; k++) begin
      oa[k] = 4'($urandom); ob[k] = 4'($urandom);
      oc[k] = 1'($urandom); os[k] = 1'($urandom);
    end
    oa[0] = 4'h7; ob[0] = 4'h1; oc[0] = 1'b0; os[0] = 1'b0;
    for (int k = 0; k < 3; k++)
      model(4, 32'(oa[k]), 32'(ob[k]), oc[k], os[k], es[k], eco[k], eov[k]);
    @(negedge clk);
    b4.ready_i = 1'b1;
    b4.operand1_i = oa[0]; b4.operand2_i = ob[0]; b4.carry_i = oc[0]; b4.sub_i = os[0];
    b4.valid_i = 1'b1;
    cyc = 0; na = 0; nr = 0;
    while (nr < 3 && cyc < 200) begin
      if (b4.valid_o) begin
        check("b2b4:sum", {26'd0, b4.overflow_o, b4.carry_o, b4.sum_o},
              {26'd0, eov[nr], eco[nr], es[nr][3:0]});
        nr++;
      end
      if (b4.valid_i && b4.ready_o && na < 3) begin
        acc_cyc[na] = cyc;
        na++;
        @(posedge clk);
        #1;
        if (na < 3) begin
          b4.operand1_i = oa[na]; b4.operand2_i = ob[na];
          b4.carry_i = oc[na]; b4.sub_i = os[na];
        end else b4.valid_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    b4.valid_i = 1'b0;
    b4.ready_i = 1'b0;
    check("b2b4:results", 32'(nr), 32'd3);
    check("b2b4:gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
    check("b2b4:gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
  endtask

  task automatic reset_mid_run();
    int seen_valid;
    @(negedge clk);
    b16.operand1_i = 16'h1234; b16.operand2_i = 16'h4321;
    b16.carry_i = 1'b0; b16.sub_i = 1'b0;
    b16.valid_i = 1'b1;
    @(posedge clk);
    #1;
    b16.valid_i = 1'b0;
    @(negedge clk);
    check("rst_run:en", 32'(b16.slice_en_o), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_run:state", {28'd0, b16.ready_o, b16.valid_o, b16.slice_en_o, b16.busy_o}, 32'h8);
    check("rst_run:slice", {23'd0, b16.slice_carry_o, b16.slice_op1_o, b16.slice_op2_o}, 32'd0);
    check("rst_run:sum", 32'(b16.sum_o), 32'd0);
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (b16.valid_o) seen_valid++;
    end
    check("rst_run:no_emit", 32'(seen_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    b16.valid_i = 1'b0; b16.ready_i = 1'b0; b16.operand1_i = '0; b16.operand2_i = '0;
    b16.carry_i = 1'b0; b16.sub_i = 1'b0;
    b4.valid_i = 1'b0;  b4.ready_i = 1'b0;  b4.operand1_i = '0;  b4.operand2_i = '0;
    b4.carry_i = 1'b0;  b4.sub_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset16:ctl", {28'd0, b16.ready_o, b16.valid_o, b16.slice_en_o, b16.busy_o}, 32'h8);
    check("reset16:out", {14'd0, b16.carry_o, b16.overflow_o, b16.sum_o}, 32'd0);
    check("reset16:slice", {23'd0, b16.slice_carry_o, b16.slice_op1_o, b16.slice_op2_o}, 32'd0);
    check("reset4:ctl", {28'd0, b4.ready_o, b4.valid_o, b4.slice_en_o, b4.busy_o}, 32'h8);

    txn16("add",      16'h1234, 16'h1111, 1'b0, 1'b0, 0, 1'b0);
    txn16("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    txn16("cin_ovf",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    txn16("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    txn16("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    txn16("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
    txn16("backpres", 16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 3, 1'b0);
    txn16("vld_run",  16'h4000, 16'h4000, 1'b0, 1'b0, 1, 1'b1);

    reset_mid_run();
    txn16("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    for (int i = 0; i < 6; i++)
      txn16("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 2)), 1'b0);

    b2b16();
    b2b4();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
